// File: rtl/lpf_capture_pkg.sv
// ============================================================================
// lpf_capture_pkg : shared types and helpers for the LPF response capture
// Revision: 1.0
// ============================================================================
`default_nettype none

package lpf_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_ARMED   = 3'd2,
      ST_POST    = 3'd3,
      ST_READOUT = 3'd4
   } cap_state_e;

   localparam int LANE_W = 16;

   // raw holds an nbits-wide two's complement sample in its LSBs
   function automatic logic [LANE_W-1:0] sign_extend_lane(input logic [LANE_W-1:0] raw,
                                                          input int nbits);
      logic [LANE_W-1:0] ext;
      ext = raw;
      for (int i = 0; i < LANE_W; i++) begin
         if (i >= nbits) ext[i] = raw[nbits-1];
      end
      return ext;
   endfunction

endpackage

`default_nettype wire

// File: rtl/capture_ring_bram.sv
// ============================================================================
// capture_ring_bram : simple dual-port ring storage, registered read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module capture_ring_bram #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 96
) (
   input  logic                     clk_i,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]         rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Read register holds its value while rd_en_i is low; the top level
   // relies on this to park a fetched beat under backpressure.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/lpf_response_capture.sv
// ============================================================================
// lpf_response_capture : trigger-centred ring capture of the LPF output with
//                        AXI4-Stream readout of the captured window
// Revision: 1.0
// ============================================================================
`default_nettype none

module lpf_response_capture
   import lpf_capture_pkg::*;
#(
   parameter int NSAMP   = 8,
   parameter int NBITS   = 12,
   parameter int DEPTH   = 512,
   parameter int PRETRIG = 100
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NSAMP*NBITS-1:0]   in_i,
   input  logic                     arm_i,
   input  logic                     trig_i,
   output logic [NSAMP*LANE_W-1:0]  m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int DW     = NSAMP * NBITS;
   localparam int AW     = $clog2(DEPTH);
   localparam int CNT_W  = AW + 1;
   localparam int POST_N = DEPTH - PRETRIG - 1;

   localparam logic [AW-1:0]    PRE_A     = AW'(PRETRIG);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PRETRIG - 1);
   localparam logic [CNT_W-1:0] POST_INIT = CNT_W'(POST_N);
   localparam logic [CNT_W-1:0] RD_END    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DEPTH - 1);

   cap_state_e       state_q,  state_d;
   logic [AW-1:0]    wptr_q,   wptr_d;
   logic [AW-1:0]    tptr_q,   tptr_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             rvalid_q, rvalid_d;
   logic             rlast_q,  rlast_d;
   logic             tvalid_q, tvalid_d;
   logic             tlast_q,  tlast_d;
   logic [DW-1:0]    tdata_q,  tdata_d;
   logic             done_q,   done_d;

   logic             wr_en;
   logic             rd_en;
   logic             out_ready;
   logic             advance;
   logic [AW-1:0]    rd_addr;
   logic [DW-1:0]    rd_data;

   capture_ring_bram #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
   ) u_ring (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q),
      .wr_data_i (in_i),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   assign rd_addr = tptr_q - PRE_A + rd_cnt_q[AW-1:0];

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      tptr_d    = tptr_q;
      cnt_d     = cnt_q;
      rd_cnt_d  = rd_cnt_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tdata_d   = tdata_q;
      done_d    = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      // The RAM read register and the output register form a two-deep
      // pipeline; a beat moves forward whenever the output slot frees up.
      out_ready = !tvalid_q || m_axis_tready;
      advance   = rvalid_q && out_ready;

      case (state_q)
         ST_IDLE: begin
            if (arm_i) begin
               wptr_d   = '0;
               cnt_d    = '0;
               rd_cnt_d = '0;
               state_d  = (PRETRIG == 0) ? ST_ARMED : ST_FILL;
            end
         end

         ST_FILL: begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + AW'(1);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == FILL_LAST) state_d = ST_ARMED;
         end

         ST_ARMED: begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + AW'(1);
            if (trig_i) begin
               tptr_d   = wptr_q;
               cnt_d    = POST_INIT;
               rd_cnt_d = '0;
               state_d  = (POST_N == 0) ? ST_READOUT : ST_POST;
            end
         end

         ST_POST: begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + AW'(1);
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_READOUT;
         end

         ST_READOUT: begin
            rd_en = (rd_cnt_q < RD_END) && (!rvalid_q || advance);
            if (advance) begin
               tvalid_d = 1'b1;
               tdata_d  = rd_data;
               tlast_d  = rlast_q;
            end else if (tvalid_q && m_axis_tready) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
            end
            if (rd_en) begin
               rvalid_d = 1'b1;
               rlast_d  = (rd_cnt_q == RD_LAST);
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end else if (advance) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
            end
            if (tvalid_q && m_axis_tready && tlast_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         wptr_q   <= '0;
         tptr_q   <= '0;
         cnt_q    <= '0;
         rd_cnt_q <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         tptr_q   <= tptr_d;
         cnt_q    <= cnt_d;
         rd_cnt_q <= rd_cnt_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
         done_q   <= done_d;
      end
   end

   for (genvar k = 0; k < NSAMP; k++) begin : g_lane
      assign m_axis_tdata[k*LANE_W +: LANE_W] =
         sign_extend_lane(LANE_W'(tdata_q[k*NBITS +: NBITS]), NBITS);
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_lpf_response_capture.sv
// ============================================================================
// tb_lpf_response_capture : randomized capture scenarios on three geometries
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lpf_response_capture;

   localparam int ND = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [95:0]       in_data;
   logic              tready;
   logic [ND-1:0]     arm_v, trig_v;
   logic [127:0]      tdata_v [ND];
   logic [ND-1:0]     tvalid_v, tlast_v, busy_v, done_v;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [95:0]  hist [int];
   logic [127:0] got_q [$];
   bit           last_q [$];
   int           first_valid, unstable;
   bit           timed_out, done_ok, done_clear;

   always #5 clk = ~clk;

   lpf_response_capture #(.NSAMP(8), .NBITS(12), .DEPTH(512), .PRETRIG(100)) dut_main (
      .clk_i(clk), .rst_i(rst), .in_i(in_data), .arm_i(arm_v[0]), .trig_i(trig_v[0]),
      .m_axis_tdata(tdata_v[0]), .m_axis_tvalid(tvalid_v[0]), .m_axis_tready(tready),
      .m_axis_tlast(tlast_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]));

   lpf_response_capture #(.NSAMP(8), .NBITS(12), .DEPTH(16), .PRETRIG(0)) dut_pre0 (
      .clk_i(clk), .rst_i(rst), .in_i(in_data), .arm_i(arm_v[1]), .trig_i(trig_v[1]),
      .m_axis_tdata(tdata_v[1]), .m_axis_tvalid(tvalid_v[1]), .m_axis_tready(tready),
      .m_axis_tlast(tlast_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]));

   lpf_response_capture #(.NSAMP(8), .NBITS(12), .DEPTH(4), .PRETRIG(3)) dut_post0 (
      .clk_i(clk), .rst_i(rst), .in_i(in_data), .arm_i(arm_v[2]), .trig_i(trig_v[2]),
      .m_axis_tdata(tdata_v[2]), .m_axis_tvalid(tvalid_v[2]), .m_axis_tready(tready),
      .m_axis_tlast(tlast_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]));

   function automatic int dep(input int d);
      return (d == 0) ? 512 : ((d == 1) ? 16 : 4);
   endfunction

   function automatic int pre(input int d);
      return (d == 0) ? 100 : ((d == 1) ? 0 : 3);
   endfunction

   function automatic logic [95:0] rand96();
      return {$urandom, $urandom, $urandom};
   endfunction

   // Expected AXI beat: each 12-bit sample interpreted as a signed number
   function automatic logic [127:0] expect_beat(input logic [95:0] raw);
      logic [127:0] r;
      int v;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         v = int'(raw[12*k +: 12]);
         if (v >= 2048) v = v - 4096;
         r[16*k +: 16] = v[15:0];
      end
      return r;
   endfunction

   // Window = the DEPTH beats presented at edges t-PRETRIG .. t+DEPTH-PRETRIG-1
   function automatic int window_bad(input int d, input int t);
      int bad;
      bad = (got_q.size() != dep(d)) ? 1 : 0;
      for (int b = 0; b < got_q.size() && b < dep(d); b++)
         if (got_q[b] !== expect_beat(hist[t - pre(d) + b])) bad++;
      return bad;
   endfunction

   function automatic int last_bad(input int d);
      int bad;
      bad = 0;
      for (int b = 0; b < last_q.size(); b++)
         if (last_q[b] != (b == dep(d) - 1)) bad++;
      return bad;
   endfunction

   task automatic tick(input int d, input bit arm, input bit trig, input logic [95:0] data);
      in_data  = data;
      arm_v    = '0;
      trig_v   = '0;
      arm_v[d] = arm;
      trig_v[d] = trig;
      hist[cyc + 1] = data;
      @(posedge clk);
      #1;
      cyc++;
      arm_v  = '0;
      trig_v = '0;
   endtask

   task automatic start_capture(input int d, input bit do_arm, input bit early,
                                input logic [95:0] tdat, output int t_edge);
      int a, wait_n;
      if (do_arm) tick(d, 1'b1, early, rand96());
      a = cyc;
      wait_n = pre(d) + $urandom_range(0, 4);
      for (int i = 0; i < wait_n; i++) tick(d, 1'b0, early && (i < pre(d)), rand96());
      tick(d, 1'b0, 1'b1, tdat);
      t_edge = cyc;
      if (t_edge < a + pre(d) + 1) $display("note: trigger placed before ARMED");
   endtask

   task automatic collect(input int d, input int max_beats, input bit rand_ready,
                          input int arm_at, input bit rearm);
      int n, budget;
      logic [127:0] prev_d;
      bit prev_l, prev_stall, hs;
      got_q.delete();
      last_q.delete();
      first_valid = -1; unstable = 0; timed_out = 0; done_ok = 0; done_clear = 0;
      n = 0; prev_stall = 0; prev_d = '0; prev_l = 0;
      budget = 6 * dep(d) + 100;
      for (int i = 0; n < max_beats; i++) begin
         if (i >= budget) begin
            timed_out = 1;
            break;
         end
         if (tvalid_v[d] && first_valid < 0) first_valid = cyc;
         if (prev_stall && (!tvalid_v[d] || tdata_v[d] !== prev_d || tlast_v[d] !== prev_l))
            unstable++;
         tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = tvalid_v[d] && tready;
         prev_stall = tvalid_v[d] && !tready;
         prev_d = tdata_v[d];
         prev_l = tlast_v[d];
         if (hs) begin
            got_q.push_back(tdata_v[d]);
            last_q.push_back(tlast_v[d]);
            n++;
         end
         tick(d, (i == arm_at), 1'b0, rand96());
      end
      tready = 1'b1;
      if (!timed_out && max_beats == dep(d)) begin
         done_ok = done_v[d] && !busy_v[d];
         tick(d, rearm, 1'b0, rand96());
         done_clear = !done_v[d];
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick(0, 1'b0, 1'b0, rand96());
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (tvalid_v[d] !== 1'b0 || tlast_v[d] !== 1'b0 || busy_v[d] !== 1'b0 ||
             done_v[d] !== 1'b0 || tdata_v[d] !== 128'h0) begin
            failures++;
            $display("FAIL reset_values dut%0d: got v=%b l=%b b=%b d=%b data=%h required all zero",
                     d, tvalid_v[d], tlast_v[d], busy_v[d], done_v[d], tdata_v[d]);
         end
      end
      rst = 1'b0;
      tick(0, 1'b0, 1'b0, rand96());
   endtask

   task automatic test_impulse();
      logic [95:0] trg;
      int t, bad;
      trg = '0;
      trg[11:0] = 12'd1000;
      start_capture(0, 1'b1, 1'b0, trg, t);
      collect(0, 512, 1'b0, -1, 1'b0);
      checks++;
      if (timed_out) begin failures++; $display("FAIL impulse_timeout: got %0d beats required 512", got_q.size()); end
      bad = window_bad(0, t);
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL impulse_window: got %0d bad beats required 0", bad); end
      checks++;
      if (got_q.size() < 101 || got_q[100][15:0] !== 16'h03E8) begin
         failures++;
         $display("FAIL impulse_beat100: got %h required 03e8", (got_q.size() > 100) ? got_q[100][15:0] : 16'hxxxx);
      end
      bad = last_bad(0);
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL impulse_tlast: got %0d misplaced required 0", bad); end
      checks++;
      if (first_valid - t !== 512 - 100 + 1) begin
         failures++;
         $display("FAIL impulse_latency: got %0d required %0d", first_valid - t, 413);
      end
      checks++;
      if (!done_ok || !done_clear) begin
         failures++;
         $display("FAIL impulse_done_pulse: got pulse=%b cleared=%b required 1 1", done_ok, done_clear);
      end
   endtask

   task automatic test_negative_backpressure();
      logic [95:0] trg;
      int t, bad;
      trg = rand96();
      trg[47:36] = 12'hC18;
      start_capture(0, 1'b1, 1'b0, trg, t);
      collect(0, 512, 1'b1, -1, 1'b0);
      checks++;
      if (got_q.size() < 101 || got_q[100][63:48] !== 16'hFC18) begin
         failures++;
         $display("FAIL negative_lane3: got %h required fc18", (got_q.size() > 100) ? got_q[100][63:48] : 16'hxxxx);
      end
      bad = window_bad(0, t);
      checks++;
      if (bad !== 0 || timed_out) begin failures++; $display("FAIL backpressure_window: got %0d bad beats (timeout=%b) required 0", bad, timed_out); end
      checks++;
      if (unstable !== 0) begin failures++; $display("FAIL backpressure_stable: got %0d changes while stalled required 0", unstable); end
      bad = last_bad(0);
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL backpressure_tlast: got %0d misplaced required 0", bad); end
      checks++;
      if (!done_ok || !done_clear) begin
         failures++;
         $display("FAIL backpressure_done: got pulse=%b cleared=%b required 1 1", done_ok, done_clear);
      end
   endtask

   task automatic test_early_trig_double_arm();
      int t, bad;
      tick(0, 1'b0, 1'b1, rand96());
      checks++;
      if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL idle_trig_ignored: got busy=%b required 0", busy_v[0]); end
      start_capture(0, 1'b1, 1'b1, rand96(), t);
      collect(0, 512, 1'b1, 3, 1'b0);
      bad = window_bad(0, t);
      checks++;
      if (bad !== 0 || timed_out) begin failures++; $display("FAIL early_trig_window: got %0d bad beats (timeout=%b) required 0", bad, timed_out); end
      checks++;
      if (!done_ok || !done_clear) begin
         failures++;
         $display("FAIL post_arm_done: got pulse=%b cleared=%b required 1 1", done_ok, done_clear);
      end
   endtask

   task automatic test_pretrig_zero();
      logic [95:0] trg;
      int t, bad;
      trg = rand96();
      start_capture(1, 1'b1, 1'b0, trg, t);
      collect(1, 16, 1'b1, -1, 1'b0);
      checks++;
      if (got_q.size() < 1 || got_q[0] !== expect_beat(trg)) begin
         failures++;
         $display("FAIL pretrig0_beat0: got %h required %h", (got_q.size() > 0) ? got_q[0] : 128'hx, expect_beat(trg));
      end
      bad = window_bad(1, t) + last_bad(1);
      checks++;
      if (bad !== 0 || timed_out) begin failures++; $display("FAIL pretrig0_window: got %0d errors required 0", bad); end
   endtask

   task automatic test_back_to_back();
      logic [95:0] trg;
      int t, bad;
      for (int r = 0; r < 2; r++) begin
         trg = rand96();
         start_capture(2, (r == 0), 1'b0, trg, t);
         collect(2, 4, 1'b0, -1, (r == 0));
         checks++;
         if (got_q.size() < 4 || got_q[3] !== expect_beat(trg) || first_valid - t !== 2) begin
            failures++;
            $display("FAIL post0_trigger_beat run%0d: got latency %0d required 2 with beat 3 = trigger", r, first_valid - t);
         end
         bad = window_bad(2, t) + last_bad(2);
         checks++;
         if (bad !== 0 || !done_ok || !done_clear) begin
            failures++;
            $display("FAIL post0_window run%0d: got %0d errors done=%b/%b required 0 1/1", r, bad, done_ok, done_clear);
         end
      end
      // second run was armed in the done cycle of the first
      checks++;
      if (busy_v[2] !== 1'b0) begin failures++; $display("FAIL back_to_back_idle: got busy=%b required 0", busy_v[2]); end
   endtask

   task automatic test_reset_mid_readout();
      int t, bad;
      start_capture(0, 1'b1, 1'b0, rand96(), t);
      collect(0, 37, 1'b1, -1, 1'b0);
      rst = 1'b1;
      tick(0, 1'b0, 1'b0, rand96());
      checks++;
      if (tvalid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || tlast_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_readout_reset: got v=%b b=%b l=%b required 0 0 0", tvalid_v[0], busy_v[0], tlast_v[0]);
      end
      rst = 1'b0;
      tick(0, 1'b0, 1'b0, rand96());
      start_capture(0, 1'b1, 1'b0, rand96(), t);
      collect(0, 512, 1'b1, -1, 1'b0);
      bad = window_bad(0, t) + last_bad(0);
      checks++;
      if (bad !== 0 || timed_out || !done_ok) begin
         failures++;
         $display("FAIL after_reset_window: got %0d errors timeout=%b done=%b required 0 0 1", bad, timed_out, done_ok);
      end
   endtask

   initial begin
      rst = 1'b1; tready = 1'b1; arm_v = '0; trig_v = '0; in_data = '0;
      test_reset();
      test_impulse();
      test_negative_backpressure();
      test_early_trig_double_arm();
      test_pretrig_zero();
      test_back_to_back();
      test_reset_mid_readout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got simulation still running required finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
